// File: rtl/fetch_stage.sv
// fetch_stage: IF pipe stage. Owns the PC, issues instruction-memory requests,
// absorbs memory latency with a FETCH/HOLD/DRAIN FSM and a one-entry hold buffer,
// and drives the IF/ID pipeline register under stall-unit and branch control.
module fetch_stage #(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        PCWrite,
    input  logic        IFIDWrite,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc_plus4,
    output logic        ifid_valid,
    output logic [31:0] pc_out
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] drain_addr;
    logic [31:0] hold_instr;
    logic [31:0] hold_pc_plus4;

    logic        stall;
    logic        done;
    logic [31:0] pc_plus4;

    // Request decode: HOLD never requests; DRAIN keeps the abandoned address
    // on the bus until memory completes it. No request while reset is held.
    assign stall     = !PCWrite || !IFIDWrite;
    assign pc_plus4  = pc + 32'd4;
    assign imem_req  = reset && (state != S_HOLD);
    assign imem_addr = (state == S_DRAIN) ? drain_addr : pc;
    assign done      = imem_req && imem_ready;
    assign pc_out    = pc;

    // FSM, PC, hold buffer and IF/ID register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= S_FETCH;
            pc            <= PC_RESET;
            drain_addr    <= '0;
            hold_instr    <= '0;
            hold_pc_plus4 <= '0;
            ifid_instr    <= NOP_INSTR;
            ifid_pc_plus4 <= '0;
            ifid_valid    <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (stall) begin
                        // Park a completed word until the stall lifts.
                        if (done) begin
                            hold_instr    <= imem_rdata;
                            hold_pc_plus4 <= pc_plus4;
                            state         <= S_HOLD;
                        end
                    end else if (branch_taken) begin
                        pc            <= branch_target;
                        ifid_instr    <= NOP_INSTR;
                        ifid_pc_plus4 <= '0;
                        ifid_valid    <= 1'b0;
                        // An in-flight request cannot be withdrawn; drain it.
                        if (!done) begin
                            drain_addr <= pc;
                            state      <= S_DRAIN;
                        end
                    end else if (done) begin
                        ifid_instr    <= imem_rdata;
                        ifid_pc_plus4 <= pc_plus4;
                        ifid_valid    <= 1'b1;
                        pc            <= pc_plus4;
                    end else begin
                        ifid_instr    <= NOP_INSTR;
                        ifid_pc_plus4 <= '0;
                        ifid_valid    <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        if (branch_taken) begin
                            pc            <= branch_target;
                            ifid_instr    <= NOP_INSTR;
                            ifid_pc_plus4 <= '0;
                            ifid_valid    <= 1'b0;
                        end else begin
                            ifid_instr    <= hold_instr;
                            ifid_pc_plus4 <= hold_pc_plus4;
                            ifid_valid    <= 1'b1;
                            pc            <= pc_plus4;
                        end
                        hold_instr    <= '0;
                        hold_pc_plus4 <= '0;
                        state         <= S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (IFIDWrite) begin
                        ifid_instr    <= NOP_INSTR;
                        ifid_pc_plus4 <= '0;
                        ifid_valid    <= 1'b0;
                    end
                    if (!stall && branch_taken) begin
                        pc <= branch_target;
                    end
                    if (done) begin
                        state <= S_FETCH;
                    end
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed test-plan scenarios followed by randomized stall,
// branch, reset and memory-latency traffic, checked cycle by cycle against a
// transaction-level reference model of the fetch stage.
module tb_fetch_stage;

    localparam logic [31:0] PC_RST = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic        clock;
    logic        reset;
    logic        PCWrite;
    logic        IFIDWrite;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;
    logic [31:0] pc_out;

    fetch_stage #(
        .PC_RESET  (PC_RST),
        .NOP_INSTR (NOP)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .PCWrite       (PCWrite),
        .IFIDWrite     (IFIDWrite),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_ready    (imem_ready),
        .ifid_instr    (ifid_instr),
        .ifid_pc_plus4 (ifid_pc_plus4),
        .ifid_valid    (ifid_valid),
        .pc_out        (pc_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory contents: a fixed function of the address.
    logic [31:0] mask;
    assign imem_rdata = imem_addr ^ mask;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ mask;
    endfunction

    int n_pass;
    int n_total;

    // Reference model: architectural PC, an outstanding abandoned fetch,
    // a queue of fetched-but-parked words, and the IF/ID contents.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } ent_t;

    logic [31:0] m_pc;
    logic        m_draining;
    logic [31:0] m_drain_addr;
    ent_t        m_buf[$];
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic m_bubble();
        m_instr = NOP;
        m_pc4   = '0;
        m_valid = 1'b0;
    endtask

    task automatic model_edge(input logic r, input logic pcw, input logic ifw,
                              input logic br, input logic [31:0] tgt, input logic rdy);
        logic stalled;
        logic [31:0] a;
        ent_t e;
        if (!r) begin
            m_pc       = PC_RST;
            m_draining = 1'b0;
            m_buf.delete();
            m_bubble();
            return;
        end
        stalled = !(pcw && ifw);
        if (m_buf.size() != 0) begin
            // A parked word is released (or dropped by a branch) once the stall lifts.
            if (!stalled) begin
                if (br) begin
                    m_pc = tgt;
                    m_bubble();
                end else begin
                    m_instr = m_buf[0].instr;
                    m_pc4   = m_buf[0].pc4;
                    m_valid = 1'b1;
                    m_pc    = m_buf[0].pc4;
                end
                m_buf.delete();
            end
        end else if (m_draining) begin
            if (ifw) m_bubble();
            if (!stalled && br) m_pc = tgt;
            if (rdy) m_draining = 1'b0;
        end else begin
            a = m_pc;
            if (stalled) begin
                if (rdy) begin
                    e.instr = mem_word(a);
                    e.pc4   = a + 32'd4;
                    m_buf.push_back(e);
                end
            end else if (br) begin
                m_pc = tgt;
                m_bubble();
                if (!rdy) begin
                    m_draining   = 1'b1;
                    m_drain_addr = a;
                end
            end else if (rdy) begin
                m_instr = mem_word(a);
                m_pc4   = a + 32'd4;
                m_valid = 1'b1;
                m_pc    = a + 32'd4;
            end else begin
                m_bubble();
            end
        end
    endtask

    // One clock cycle: drive, check the request bus, clock, check state.
    task automatic step(input logic r, input logic pcw, input logic ifw,
                        input logic br, input logic [31:0] tgt, input logic rdy);
        logic exp_req;
        reset         = r;
        PCWrite       = pcw;
        IFIDWrite     = ifw;
        branch_taken  = br;
        branch_target = tgt;
        imem_ready    = rdy;
        #1;
        exp_req = r && (m_buf.size() == 0);
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) chk("imem_addr", imem_addr, m_draining ? m_drain_addr : m_pc);
        @(posedge clock);
        model_edge(r, pcw, ifw, br, tgt, rdy);
        #1;
        chk("ifid_instr", ifid_instr, m_instr);
        chk("ifid_pc_plus4", ifid_pc_plus4, m_pc4);
        chk("ifid_valid", 32'(ifid_valid), 32'(m_valid));
        chk("pc_out", pc_out, m_pc);
    endtask

    initial begin
        logic        r;
        logic        pcw;
        logic        ifw;
        logic        br;
        logic [31:0] tgt;
        logic        rdy;

        n_pass        = 0;
        n_total       = 0;
        mask          = 32'h0;
        reset         = 1'b0;
        PCWrite       = 1'b1;
        IFIDWrite     = 1'b1;
        branch_taken  = 1'b0;
        branch_target = '0;
        imem_ready    = 1'b0;
        m_pc          = PC_RST;
        m_draining    = 1'b0;
        m_drain_addr  = '0;
        m_instr       = NOP;
        m_pc4         = '0;
        m_valid       = 1'b0;

        // Reset, then zero-wait memory returning address as data.
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("rst_valid", 32'(ifid_valid), 32'h0);
        chk("rst_instr", ifid_instr, NOP);
        chk("rst_pc", pc_out, PC_RST);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
            chk("zw_instr", ifid_instr, 32'(i * 4));
            chk("zw_pc4", ifid_pc_plus4, 32'(i * 4 + 4));
            chk("zw_valid", 32'(ifid_valid), 32'h1);
        end

        // Stall three cycles while the fetch at 0x10 completes.
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("hold_req", 32'(imem_req), 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("hold_ifid", ifid_instr, 32'hC);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("rel_instr", ifid_instr, 32'h10);
        chk("rel_pc4", ifid_pc_plus4, 32'h14);
        chk("rel_next", imem_addr, 32'h14);

        // Two wait cycles per request.
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
            chk("wait_bubble", 32'(ifid_valid), 32'h0);
            step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
            step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        end
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("pre_br_pc", pc_out, 32'h20);

        // Branch to 0x100 while the 0x20 request waits three cycles.
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h100, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("drain_addr", imem_addr, 32'h20);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("post_drain_addr", imem_addr, 32'h100);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("br_pc4", ifid_pc_plus4, 32'h104);

        // Branch during stall is ignored; re-presented branch on release redirects.
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0);
        chk("stall_br_pc", pc_out, 32'h104);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h200, 1'b1);
        chk("rel_br_pc", pc_out, 32'h200);

        // Reset in DRAIN, then reset in HOLD.
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h300, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("rst_drain_pc", pc_out, PC_RST);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("rst_hold_pc", pc_out, PC_RST);
        chk("rst_hold_valid", 32'(ifid_valid), 32'h0);

        // PC wrap at the top of the address space.
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("wrap_instr", ifid_instr, 32'hFFFF_FFFC);
        chk("wrap_pc4", ifid_pc_plus4, 32'h0);
        chk("wrap_pc", pc_out, 32'h0);

        // Randomized traffic.
        mask = 32'h5A5A_0000;
        for (int n = 0; n < 3000; n++) begin
            r   = ($urandom_range(99) >= 2);
            pcw = ($urandom_range(99) >= 20);
            ifw = ($urandom_range(99) >= 20);
            br  = ($urandom_range(99) < 15);
            tgt = $urandom;
            tgt[1:0] = 2'b00;
            if ($urandom_range(19) == 0) tgt = 32'hFFFF_FFFC;
            rdy = ($urandom_range(99) < 60);
            step(r, pcw, ifw, br, tgt, rdy);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF pipe stage feeding the ID stage's main control and stall detection.
- Owns the PC, issues requests to instruction memory, and drives the IF/ID pipeline register.
- Obeys the stall unit's PCWrite/IFIDWrite and redirects on taken branches resolved in ID.
- Absorbs variable instruction-memory latency with a 3-state FSM and a one-entry hold buffer.

Parameters:
PC_RESET, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, instruction word injected into IF/ID on bubble/flush (sll r0,r0,0)

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-low; reset==0 at a rising edge resets the block
PCWrite  input  1  from stall unit; 0 = hold PC
IFIDWrite  input  1  from stall unit; 0 = hold IF/ID register
branch_taken  input  1  taken beq resolved in ID this cycle
branch_target  input  32  redirect address, valid with branch_taken
imem_req  output  1  instruction fetch request
imem_addr  output  32  fetch address, stable while imem_req=1 and imem_ready=0
imem_rdata  input  32  instruction word, valid when imem_req && imem_ready
imem_ready  input  1  memory accepts/completes request this cycle (0+ wait cycles)
ifid_instr  output  32  IF/ID instruction
ifid_pc_plus4  output  32  IF/ID PC+4
ifid_valid  output  1  IF/ID holds a real instruction
pc_out  output  32  current PC (debug)

Behaviour:
- Reset (reset==0 at edge): PC=PC_RESET, state=FETCH, hold buffer empty, ifid_instr=NOP_INSTR, ifid_pc_plus4=0, ifid_valid=0. First imem_req=1 in the cycle after reset deasserts.
- Handshake:
  - A request completes when imem_req && imem_ready.
  - Once raised, imem_req stays 1 with imem_addr unchanged until completion; a request is never withdrawn.
- PC arithmetic: 32-bit PC+4, wraps mod 2^32 (32'hFFFF_FFFC -> 0), no flag.
- Priority each cycle: reset > stall (PCWrite=0 or IFIDWrite=0) > branch_taken > normal.
  - branch_taken is ignored while stalled; ID re-presents it.
- FETCH state: imem_req=1, imem_addr=PC.
  - Complete, no stall, no branch: IF/ID <= {imem_rdata, PC+4, valid=1}; PC <= PC+4; stay FETCH. Zero-wait memory gives 1 instr/cycle.
  - Complete while stalled: word and PC+4 go to the hold buffer; PC unchanged; IF/ID held; -> HOLD.
  - Not complete, no stall: IF/ID <= bubble {NOP_INSTR, 0, valid=0}; stay FETCH.
  - Not complete while stalled: IF/ID held; stay FETCH.
  - branch_taken with completion this cycle: data discarded; PC <= branch_target; IF/ID <= bubble; stay FETCH.
  - branch_taken without completion: drain_addr <= PC; PC <= branch_target; IF/ID <= bubble; -> DRAIN.
- HOLD state: imem_req=0.
  - Stall persists: everything held.
  - Stall released, no branch: IF/ID <= buffer (valid=1); PC <= PC+4; buffer cleared; -> FETCH.
  - Stall released with branch_taken: buffer dropped; PC <= branch_target; IF/ID <= bubble; -> FETCH.
- DRAIN state: imem_req=1, imem_addr=drain_addr.
  - On completion, data discarded -> FETCH.
  - IF/ID <= bubble each DRAIN cycle unless IFIDWrite=0.
  - A further branch_taken in DRAIN updates PC only; state unchanged.
- Outputs:
  - IF/ID outputs are registered.
  - imem_req and imem_addr are decoded from state and registers, never combinationally from imem_ready.
- Reset mid-operation (any state): returns to the reset values above. A pending memory response is not waited for; the memory model must tolerate the abandoned request.
- The stall unit's StallControl (ID/EX bubble) is not used here.

Test Plan:
- Reset with PC_RESET=0, zero-wait memory returning addr-as-data, 4 cycles -> ifid_instr 0,4,8,C on consecutive cycles, ifid_pc_plus4 4,8,C,10, ifid_valid=1 from cycle 2.
- imem_ready delayed 2 cycles per request -> imem_addr stable during wait, two bubbles (valid=0, instr=NOP_INSTR) between real instrs, PC steps by 4 per completion.
- PCWrite=IFIDWrite=0 for 3 cycles while completing fetch at 0x10 -> HOLD, imem_req=0, IF/ID unchanged; on release ifid_instr=word@0x10, pc_plus4=0x14, next fetch 0x14.
- branch_taken to 0x100 while request at 0x20 waits 3 cycles -> imem_addr stays 0x20 until ready, data dropped, IF/ID bubbles, next request at 0x100, then ifid_pc_plus4=0x104.
- branch_taken together with stall -> branch ignored, PC and IF/ID held; branch on release -> PC=target.
- Reset asserted in DRAIN and HOLD; also PC=32'hFFFF_FFFC zero-wait -> reset values restored, next fetch at PC_RESET; wrap gives next fetch 0, pc_plus4=0.
